// File: rtl/tnn_feature_sequencer.sv
`default_nettype none
// ============================================================================
// tnn_feature_sequencer: serial feature assembly, fixed-latency classifier run
// window and valid/ready result delivery for a sequential ternary classifier.
// Revision: 1.0
// ============================================================================
module tnn_feature_sequencer #(
    parameter int FEAT_CNT  = 11,
    parameter int FEAT_BITS = 4,
    parameter int CLASS_CNT = 6,
    parameter int LATENCY   = 48,
    parameter int TEST_CNT  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS-1:0]          in_feat,
    output logic [FEAT_CNT*FEAT_BITS-1:0] data,
    output logic                          tnn_run,
    input  logic [$clog2(CLASS_CNT)-1:0]  tnn_pred,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  out_pred,
    output logic [$clog2(TEST_CNT+1)-1:0] sample_idx,
    output logic                          all_done
);
    // Counters keep at least one bit so degenerate parameter values still elaborate.
    localparam int FEAT_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int RUN_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W  = $clog2(TEST_CNT + 1);

    localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(FEAT_CNT - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0]  IDX_FINAL = IDX_W'(TEST_CNT);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FEAT_W-1:0] r_feat_cnt;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              w_feat_acc;
    logic              w_feat_last;
    logic              w_run_last;
    logic              w_out_acc;
    logic [IDX_W-1:0]  w_idx_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        tnn_run     = 1'b0;
        out_valid   = 1'b0;
        all_done    = 1'b0;
        w_feat_acc  = 1'b0;
        w_feat_last = 1'b0;
        w_run_last  = 1'b0;
        w_out_acc   = 1'b0;
        w_idx_inc   = sample_idx + 1'b1;
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                in_ready    = 1'b1;
                w_feat_acc  = in_valid;
                w_feat_last = w_feat_acc && (r_feat_cnt == FEAT_LAST);
                if (w_feat_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                tnn_run    = 1'b1;
                w_run_last = (r_run_cnt == RUN_LAST);
                if (w_run_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                w_out_acc = out_ready;
                if (w_out_acc) begin
                    w_state_nxt = (w_idx_inc == IDX_FINAL) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                all_done = 1'b1;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Feature slots: the slot index is the count of features already accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data       <= '0;
            r_feat_cnt <= '0;
        end else if (w_feat_acc) begin
            for (int i = 0; i < FEAT_CNT; i++) begin
                if (r_feat_cnt == FEAT_W'(i)) begin
                    data[i*FEAT_BITS +: FEAT_BITS] <= in_feat;
                end
            end
            r_feat_cnt <= w_feat_last ? '0 : r_feat_cnt + 1'b1;
        end
    end

    // The run counter stops at LATENCY-1 instead of wrapping; it is rearmed on entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run_cnt <= '0;
            out_pred  <= '0;
        end else if (w_feat_last) begin
            r_run_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (w_run_last) begin
                out_pred <= tnn_pred;
            end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_idx <= '0;
        end else if (w_out_acc) begin
            sample_idx <= w_idx_inc;
        end
    end

endmodule
`default_nettype wire

// File: doc/tnn_feature_sequencer.md
Name: tnn_feature_sequencer

Overview:
- Upstream/downstream glue stage for the sequential ternary classifier wrapper (seq_tnn instance inside winered_ts).
- Accepts features serially, one FEAT_BITS-wide value per handshake, and assembles them into the packed FEAT_CNT*FEAT_BITS data word.
- Holds that word stable while the classifier runs for a fixed LATENCY cycles, then captures the prediction and presents it with a valid/ready handshake.
- Counts delivered results and stops after TEST_CNT samples.

Parameters:
- FEAT_CNT, 11: features per sample
- FEAT_BITS, 4: bits per feature
- CLASS_CNT, 6: number of classes; prediction width is $clog2(CLASS_CNT)
- LATENCY, 48: cycles from run assertion until the classifier prediction is valid (≥1)
- TEST_CNT, 1000: samples processed before the block enters DONE

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  serial feature valid
- in_ready  out  1  block accepts a feature this cycle
- in_feat  in  FEAT_BITS  feature value
- data  out  FEAT_CNT*FEAT_BITS  packed features to the classifier; feature i occupies [i*FEAT_BITS +: FEAT_BITS]
- tnn_run  out  1  high while the classifier evaluates the held data
- tnn_pred  in  $clog2(CLASS_CNT)  prediction from the classifier
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_pred  out  $clog2(CLASS_CNT)  captured prediction
- sample_idx  out  $clog2(TEST_CNT+1)  number of results already delivered
- all_done  out  1  TEST_CNT results delivered

Behaviour:
- States: LOAD, RUN, OUT, DONE.
- Reset (rst==0 at clk edge):
  - state=LOAD.
  - feat_cnt=0, run_cnt=0, sample_idx=0.
  - data=0, out_pred=0.
  - in_ready=1 (combinational from state), tnn_run=0, out_valid=0, all_done=0.
  - Reset mid-operation aborts the sample in progress; no partial result is emitted.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready, write in_feat into slot feat_cnt and increment feat_cnt.
  - The first accepted feature lands in slot 0 (LSBs).
  - On acceptance when feat_cnt==FEAT_CNT-1: feat_cnt wraps to 0, run_cnt=0, next state RUN.
  - in_valid low: no change.
- RUN:
  - in_ready=0, tnn_run=1.
  - data is frozen for the whole state.
  - run_cnt increments each cycle.
  - In the cycle where run_cnt==LATENCY-1: capture out_pred<=tnn_pred, next state OUT.
  - A sample therefore spends exactly LATENCY cycles in RUN.
- OUT:
  - out_valid=1, tnn_run=0, in_ready=0.
  - out_pred is stable until accepted.
  - On out_valid&&out_ready: sample_idx increments. Next state is DONE if the incremented value equals TEST_CNT, else LOAD.
  - data keeps its last value and is overwritten slot by slot during the next LOAD.
- DONE:
  - all_done=1; in_ready=0, out_valid=0, tnn_run=0.
  - Held until reset.
- Throughput: at most one result per FEAT_CNT+LATENCY+1 cycles with no stalls. There is no overlap of load and run.
- out_valid must not drop without an accepting handshake (AXI-style stability).
- Counter widths:
  - feat_cnt: $clog2(FEAT_CNT).
  - run_cnt: $clog2(LATENCY).
  - No counter may wrap except feat_cnt at FEAT_CNT-1.

Test Plan:
- Reset then stream features 1..11 (in_valid held high): in_ready drops after the 11th accept. data==44'hBA987654321. tnn_run is high for exactly 48 cycles. out_valid rises the next cycle with out_pred equal to tnn_pred as sampled in the last RUN cycle (drive 3 -> out_pred=3).
- Random gaps in in_valid during LOAD: data is identical to the gap-free case. RUN starts only after the 11th accept.
- out_ready held low 20 cycles in OUT: out_valid and out_pred stay constant, in_ready stays 0, sample_idx unchanged. On release sample_idx goes 0->1 and LOAD resumes.
- rst asserted low in the 20th RUN cycle: the next cycle shows LOAD state, in_ready=1, tnn_run=0, data=0, sample_idx=0, and no out_valid pulse.
- TEST_CNT=3, LATENCY=2: after 3 accepted results all_done=1, in_ready=0, sample_idx=3. Further in_valid is ignored until reset.
- in_valid asserted during RUN/OUT: no feature is captured and data is unchanged.
